drec_adc_if: RTL and testbench

Serial front end for the recorder's ADC128S022-style 12-bit SPI ADC. Generates the audio sample rate, runs one 16-SCLK conversion frame per sample period, and presents each result on `adc_data` with a single-cycle `adc_enable` strobe. It sits directly upstream of `drec_controller`, which consumes `adc_data` and `adc_enable` in Record mode.

---
 rtl/drec_adc_if.sv | 273 +++++++++++++++++++++++++++
 tb/tb_drec_adc_if.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drec_adc_if.sv
// ---------------------------------------------------------------------------
// drec_adc_if
//
// Serial front end for a 12-bit ADC128S022-style SPI converter.
//
// A sample-rate generator produces one tick every SAMPLE_DIV clk cycles while
// `enable` is high. Each accepted tick starts one 16-SCLK conversion frame:
//
//   SETUP (1 phase)  : chip select low, SCLK still high
//   SHIFT (32 phases): 16 SCLK periods, low half first; the address bit is
//                      driven on each falling edge and adc_dout is sampled
//                      on each rising edge (MSB first)
//   HOLD  (1 phase)  : SCLK high, then the frame closes on a single edge
//                      (chip select high, result latched, strobe raised)
//
// Every phase lasts CLK_DIV clk cycles, so chip select is low for exactly
// 34*CLK_DIV cycles and the strobe follows the tick by 34*CLK_DIV+1 cycles.
// A tick that arrives while a frame is in flight is dropped and flagged on
// `overrun` during that same cycle; the running frame is not disturbed.
//
// Parameters
//   CLK_DIV    : clk cycles per SCLK half-period (>= 1)
//   SAMPLE_DIV : clk cycles per sample period (>= 34*CLK_DIV+2 for no overrun)
//   CHANNEL    : ADC input channel address sent in every frame
//
// Ports
//   clk        in   system clock, all state on its rising edge
//   rst_n      in   synchronous active-low reset
//   enable     in   runs the sample-rate generator while high
//   adc_cs_n   out  ADC chip select, active low
//   adc_sclk   out  ADC serial clock, idles high
//   adc_din    out  serial address to the ADC
//   adc_dout   in   serial data from the ADC
//   adc_data   out  last converted sample (unsigned), held between strobes
//   adc_enable out  one-cycle strobe, adc_data valid in the same cycle
//   overrun    out  one-cycle pulse when a sample tick is dropped
// ---------------------------------------------------------------------------
module drec_adc_if #(
    parameter int         CLK_DIV    = 8,
    parameter int         SAMPLE_DIV = 1134,
    parameter logic [2:0] CHANNEL    = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] adc_data,
    output logic        adc_enable,
    output logic        overrun
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SMP_W = $clog2(SAMPLE_DIV);

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [4:0]       HALF_LAST  = 5'd31;
    // Address word shifted out MSB first: two don't-care zeros, the channel
    // in bits 13:11, zeros for the rest of the frame.
    localparam logic [15:0]      FRAME_WORD = {2'b00, CHANNEL, 11'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers and wires
    // -----------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;

    logic [SMP_W-1:0]   r_smp_cnt;
    logic               r_smp_armed;
    logic               w_tick;

    logic [PH_W-1:0]    r_phase_cnt;
    logic               w_phase_end;
    logic [4:0]         r_half;

    logic               r_cs_n;
    logic               r_sclk;
    logic               r_din;
    logic [15:0]        r_addr_sr;
    logic [11:0]        r_shift;
    logic [11:0]        r_adc_data;
    logic               r_adc_enable;

    logic               w_start;
    logic               w_sclk_fall;
    logic               w_sclk_rise;
    logic               w_frame_done;
    logic               w_overrun;

    // -----------------------------------------------------------------------
    // Sample-rate generator
    //
    // The first cycle with enable high only arms the counter, so the first
    // tick lands exactly SAMPLE_DIV cycles after enable rises and every
    // later tick is SAMPLE_DIV cycles after the previous one.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smp_cnt   <= '0;
            r_smp_armed <= 1'b0;
        end else if (!enable) begin
            r_smp_cnt   <= '0;
            r_smp_armed <= 1'b0;
        end else begin
            r_smp_armed <= 1'b1;
            if (r_smp_armed) begin
                if (r_smp_cnt == SMP_LAST) begin
                    r_smp_cnt <= '0;
                end else begin
                    r_smp_cnt <= r_smp_cnt + SMP_W'(1);
                end
            end
        end
    end

    assign w_tick = enable & r_smp_armed & (r_smp_cnt == SMP_LAST);

    // -----------------------------------------------------------------------
    // Phase timing: every non-IDLE phase is CLK_DIV cycles long
    // -----------------------------------------------------------------------
    assign w_phase_end = (r_phase_cnt == PH_LAST);

    // -----------------------------------------------------------------------
    // Frame FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: next state and datapath control
    //
    // In SHIFT, r_half is the half-period index: even = SCLK low phase,
    // odd = SCLK high phase. The end of an even phase is an SCLK rising edge
    // (sample adc_dout); the end of an odd phase is the next falling edge
    // (drive the next address bit), except after half 31 where the frame
    // moves to HOLD with SCLK left high.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_sclk_fall  = 1'b0;
        w_sclk_rise  = 1'b0;
        w_frame_done = 1'b0;
        w_overrun    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_next = ST_SETUP;
                    w_start      = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_phase_end) begin
                    w_state_next = ST_SHIFT;
                    w_sclk_fall  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_phase_end) begin
                    if (!r_half[0]) begin
                        w_sclk_rise = 1'b1;
                    end else if (r_half == HALF_LAST) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_sclk_fall = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_phase_end) begin
                    w_state_next = ST_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A tick that finds a frame in flight is simply lost.
        if (w_tick && (r_state != ST_IDLE)) begin
            w_overrun = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: phase counters, SPI pins, shift registers, result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase_cnt  <= '0;
            r_half       <= '0;
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b1;
            r_din        <= 1'b0;
            r_addr_sr    <= '0;
            r_shift      <= '0;
            r_adc_data   <= '0;
            r_adc_enable <= 1'b0;
        end else begin
            r_adc_enable <= 1'b0;

            if ((r_state == ST_IDLE) || w_phase_end) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + PH_W'(1);
            end

            if (r_state == ST_SHIFT) begin
                if (w_phase_end) begin
                    r_half <= r_half + 5'd1;
                end
            end else begin
                r_half <= '0;
            end

            if (w_start) begin
                r_cs_n    <= 1'b0;
                r_addr_sr <= FRAME_WORD;
            end

            if (w_sclk_fall) begin
                r_sclk    <= 1'b0;
                r_din     <= r_addr_sr[15];
                r_addr_sr <= {r_addr_sr[14:0], 1'b0};
            end

            // Only the last 12 samples are kept; the four leading bits the
            // ADC sends are always zero and fall off the top.
            if (w_sclk_rise) begin
                r_sclk  <= 1'b1;
                r_shift <= {r_shift[10:0], adc_dout};
            end

            if (w_frame_done) begin
                r_cs_n       <= 1'b1;
                r_din        <= 1'b0;
                r_adc_data   <= r_shift;
                r_adc_enable <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign adc_cs_n   = r_cs_n;
    assign adc_sclk   = r_sclk;
    assign adc_din    = r_din;
    assign adc_data   = r_adc_data;
    assign adc_enable = r_adc_enable;
    assign overrun    = w_overrun;

endmodule

// File: tb/tb_drec_adc_if.sv
// ---------------------------------------------------------------------------
// tb_drec_adc_if
//
// Two instances of drec_adc_if, each with a behavioural ADC model:
//   A: CLK_DIV=2, SAMPLE_DIV=100, CHANNEL=5 (conversion, rate, channel,
//      enable drop, mid-frame reset)
//   B: CLK_DIV=4, SAMPLE_DIV=100, CHANNEL=0 (136-cycle frame, overrun)
// The ADC model returns 12'hA5C for channel 0 and 12'h3C0+frame for
// channel 5 on device A, 12'h700+frame on device B. The address sent in a
// frame selects the channel converted in the following frame.
// ---------------------------------------------------------------------------
module tb_drec_adc_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        en_a, en_b;
    logic        cs_n_a, sclk_a, din_a, dout_a, strobe_a, ov_a;
    logic [11:0] data_a;
    logic        cs_n_b, sclk_b, din_b, dout_b, strobe_b, ov_b;
    logic [11:0] data_b;

    drec_adc_if #(.CLK_DIV(2), .SAMPLE_DIV(100), .CHANNEL(3'd5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a),
        .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .adc_din(din_a), .adc_dout(dout_a),
        .adc_data(data_a), .adc_enable(strobe_a), .overrun(ov_a)
    );

    drec_adc_if #(.CLK_DIV(4), .SAMPLE_DIV(100), .CHANNEL(3'd0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_din(din_b), .adc_dout(dout_b),
        .adc_data(data_b), .adc_enable(strobe_b), .overrun(ov_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // ADC model A plus frame statistics
    // -----------------------------------------------------------------------
    function automatic logic [15:0] adc_word_a(input logic [2:0] ch, input int n);
        if (ch == 3'd0)      return 16'h0A5C;
        else if (ch == 3'd5) return {4'h0, 12'h3C0 + 12'(n)};
        else                 return 16'h0EEE;
    endfunction

    int          frames_a = 0, strobes_a = 0, ov_cnt_a = 0;
    int          sclk_bad = 0, din_bad = 0;
    int          last_len_a = 0, last_falls_a = 0;
    logic [15:0] last_din_a = '0;

    initial begin
        logic        prev_cs, prev_sclk, prev_din;
        logic [2:0]  ch_a, ch_new_a;
        logic [15:0] word_a, din_w_a;
        int          fall_cyc_a, falls_a, rises_a;
        prev_cs = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0;
        ch_a = 3'd0; ch_new_a = 3'd0; word_a = '0; din_w_a = '0;
        fall_cyc_a = 0; falls_a = 0; rises_a = 0;
        dout_a = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs && !cs_n_a) begin
                frames_a++;
                fall_cyc_a = cyc;
                falls_a = 0; rises_a = 0; din_w_a = '0;
                word_a = adc_word_a(ch_a, frames_a);
                dout_a = word_a[15];
            end
            if (!cs_n_a && prev_sclk && !sclk_a) begin
                if (falls_a < 16) dout_a = word_a[15 - falls_a];
                falls_a++;
            end
            if (!cs_n_a && !prev_sclk && sclk_a) begin
                if (rises_a >= 2 && rises_a <= 4) ch_new_a = {ch_new_a[1:0], din_a};
                din_w_a = {din_w_a[14:0], din_a};
                rises_a++;
            end
            if (!prev_cs && cs_n_a) begin
                last_len_a   = cyc - fall_cyc_a;
                last_falls_a = falls_a;
                last_din_a   = din_w_a;
                if (rises_a >= 5) ch_a = ch_new_a;
            end
            if (strobe_a === 1'b1) begin
                strobes_a++;
                $display("A strobe cycle %0d data 0x%03h", cyc, data_a);
            end
            if (ov_a === 1'b1) ov_cnt_a++;
            if (cs_n_a === 1'b1 && sclk_a !== 1'b1) sclk_bad++;
            if ((din_a !== prev_din) && !(prev_sclk && !sclk_a) && !(!prev_cs && cs_n_a)) din_bad++;
            prev_cs = cs_n_a; prev_sclk = sclk_a; prev_din = din_a;
        end
    end

    // -----------------------------------------------------------------------
    // ADC model B plus event logs
    // -----------------------------------------------------------------------
    int          frames_b = 0;
    int          sb_cyc[$];
    logic [11:0] sb_dat[$];
    int          ovb_cyc[$];
    int          lenb[$];

    initial begin
        logic        prev_cs, prev_sclk;
        logic [15:0] word_b;
        int          fall_cyc_b, falls_b;
        prev_cs = 1'b1; prev_sclk = 1'b1; word_b = '0;
        fall_cyc_b = 0; falls_b = 0;
        dout_b = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs && !cs_n_b) begin
                frames_b++;
                fall_cyc_b = cyc;
                falls_b = 0;
                word_b = {4'h0, 12'h700 + 12'(frames_b)};
                dout_b = word_b[15];
            end
            if (!cs_n_b && prev_sclk && !sclk_b) begin
                if (falls_b < 16) dout_b = word_b[15 - falls_b];
                falls_b++;
            end
            if (!prev_cs && cs_n_b) lenb.push_back(cyc - fall_cyc_b);
            if (strobe_b === 1'b1) begin
                sb_cyc.push_back(cyc);
                sb_dat.push_back(data_b);
                $display("B strobe cycle %0d data 0x%03h", cyc, data_b);
            end
            if (ov_b === 1'b1) begin
                ovb_cyc.push_back(cyc);
                $display("B overrun cycle %0d", cyc);
            end
            prev_cs = cs_n_b; prev_sclk = sclk_b;
        end
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic wait_strobe(input int budget, output int at_cyc, output logic ok);
        ok = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (strobe_a === 1'b1) begin
                at_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_fall(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cs_n_a === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One cycle after a strobe: strobe gone, previous frame's shape correct.
    task automatic check_frame(input int n);
        @(negedge clk);
        check_val($sformatf("f%0d_strobe_width", n), strobe_a, 1'b0);
        check_val($sformatf("f%0d_cs_low_cycles", n), last_len_a, 68);
        check_val($sformatf("f%0d_sclk_falls", n), last_falls_a, 16);
        check_val($sformatf("f%0d_din_word", n), last_din_a, 16'h2800);
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        int   c0, c1, r, s, prev_s, n_str;
        logic ok;

        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cs_n", cs_n_a, 1'b1);
        check_val("rst_sclk", sclk_a, 1'b1);
        check_val("rst_din", din_a, 1'b0);
        check_val("rst_data", data_a, 12'h000);
        check_val("rst_strobe", strobe_a, 1'b0);
        check_val("rst_overrun", ov_a, 1'b0);
        check_val("rst_b_cs_n", cs_n_b, 1'b1);
        check_val("rst_b_sclk", sclk_b, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Enable both; first tick 100 cycles later, strobe 69 after the tick.
        c0 = cyc;
        en_a = 1'b1; en_b = 1'b1;
        wait_strobe(400, s, ok);
        check_val("f1_seen", ok, 1'b1);
        check_val("f1_latency", s - c0, 169);
        check_val("f1_data_ch0", data_a, 12'hA5C);
        check_frame(1);
        prev_s = s;

        // Channel 5 data from frame 2 on, strobes 100 cycles apart.
        for (int n = 2; n <= 4; n++) begin
            wait_strobe(200, s, ok);
            check_val($sformatf("f%0d_seen", n), ok, 1'b1);
            check_val($sformatf("f%0d_period", n), s - prev_s, 100);
            check_val($sformatf("f%0d_data_ch5", n), data_a, 12'h3C0 + n);
            check_frame(n);
            prev_s = s;
        end

        // Enable drop 10 cycles into frame 5: it finishes, nothing follows.
        wait_cs_fall(200, ok);
        check_val("f5_cs_fall_seen", ok, 1'b1);
        repeat (10) @(negedge clk);
        en_a = 1'b0;
        wait_strobe(200, s, ok);
        check_val("f5_seen", ok, 1'b1);
        check_val("f5_data", data_a, 12'h3C5);
        check_frame(5);
        n_str = strobes_a;
        repeat (300) @(negedge clk);
        check_val("disabled_no_frames", frames_a, 5);
        check_val("disabled_no_strobes", strobes_a, n_str);

        // Re-enable: first strobe at SAMPLE_DIV + 34*CLK_DIV + 1.
        c1 = cyc;
        en_a = 1'b1;
        wait_strobe(400, s, ok);
        check_val("f6_seen", ok, 1'b1);
        check_val("f6_reenable_latency", s - c1, 169);
        check_val("f6_data", data_a, 12'h3C6);
        check_frame(6);

        // Reset 20 cycles into frame 7 (inside SHIFT) aborts it.
        wait_cs_fall(300, ok);
        check_val("f7_cs_fall_seen", ok, 1'b1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        r = cyc;
        check_val("midrst_cs_n", cs_n_a, 1'b1);
        check_val("midrst_sclk", sclk_a, 1'b1);
        check_val("midrst_din", din_a, 1'b0);
        check_val("midrst_strobe", strobe_a, 1'b0);
        check_val("midrst_data", data_a, 12'h000);
        wait_strobe(400, s, ok);
        check_val("f8_seen", ok, 1'b1);
        check_val("f8_latency_after_reset", s - r, 169);
        check_val("f8_data", data_a, 12'h3C8);
        check_frame(8);

        // Device A invariants over the whole run.
        check_val("a_overrun_count", ov_cnt_a, 0);
        check_val("a_sclk_low_while_cs_high", sclk_bad, 0);
        check_val("a_din_change_off_fall", din_bad, 0);

        // Device B: 136-cycle frames on a 100-cycle period, every other tick lost.
        check_val("b_strobe_count_ge3", sb_cyc.size() >= 3, 1'b1);
        check_val("b_overrun_count_ge3", ovb_cyc.size() >= 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < sb_cyc.size()) begin
                check_val($sformatf("b_strobe%0d_cycle", i), sb_cyc[i] - c0, 237 + 200 * i);
                check_val($sformatf("b_strobe%0d_data", i), sb_dat[i], 12'h701 + i);
            end
            if (i < ovb_cyc.size()) begin
                check_val($sformatf("b_overrun%0d_cycle", i), ovb_cyc[i] - c0, 200 + 200 * i);
            end
            if (i < lenb.size()) begin
                check_val($sformatf("b_frame%0d_cs_low", i), lenb[i], 136);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
